// File: rtl/rev_addsub_seq.sv
// Digit-serial add/subtract unit built from reversible Peres-gate full adders.
// Processes DIGIT bits per cycle, LSB digit first, behind valid/ready handshakes.

// Peres gate: P = A, Q = A ^ B, R = (A & B) ^ C
module peres_gate (
    input  logic a_p,
    input  logic b_p,
    input  logic c_p,
    output logic p_p,
    output logic q_p,
    output logic r_p
);
    assign p_p = a_p;
    assign q_p = a_p ^ b_p;
    assign r_p = (a_p & b_p) ^ c_p;
endmodule

module rev_addsub_seq #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             parity,
    output logic             sign,
    output logic             overflow
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    generate
        if ((WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
            $error("rev_addsub_seq: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;
    logic             r_parity;
    logic             r_sign;
    logic             r_overflow;

    logic [DIGIT:0]   w_c;
    logic [DIGIT-1:0] w_sum;
    logic [WIDTH-1:0] w_full;

    assign w_c[0] = r_c;

    // Ripple chain of DIGIT Peres full-adder cells over the low digit of the operand shifters
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            logic w_unused_p1;
            logic w_unused_p2;
            logic w_q1;
            logic w_r1;
            logic w_r2;

            peres_gate u_pg1 (
                .a_p (r_a[i]),
                .b_p (r_b[i]),
                .c_p (1'b0),
                .p_p (w_unused_p1),
                .q_p (w_q1),
                .r_p (w_r1)
            );

            peres_gate u_pg2 (
                .a_p (w_q1),
                .b_p (w_c[i]),
                .c_p (1'b0),
                .p_p (w_unused_p2),
                .q_p (w_sum[i]),
                .r_p (w_r2)
            );

            assign w_c[i+1] = w_r1 ^ w_r2;
        end
    endgenerate

    // Sum digits enter at the top of the accumulator and shift down, so digit 0 lands at the LSB after NDIG steps
    always_comb begin
        w_full = (r_acc >> DIGIT) | (WIDTH'(w_sum) << (WIDTH - DIGIT));
    end

    // Control FSM, operand shifters, accumulator and registered result/flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_c         <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
            r_parity    <= 1'b0;
            r_sign      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= op_sub ? ~b : b;
                        r_c     <= op_sub;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_acc <= w_full;
                    r_a   <= r_a >> DIGIT;
                    r_b   <= r_b >> DIGIT;
                    r_c   <= w_c[DIGIT];
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        // On the last digit the operand MSBs sit at the top of the low digit
                        r_result    <= w_full;
                        r_carry     <= w_c[DIGIT];
                        r_zero      <= (w_full == '0);
                        r_parity    <= ^w_full;
                        r_sign      <= w_full[WIDTH-1];
                        r_overflow  <= (r_a[DIGIT-1] == r_b[DIGIT-1]) &&
                                       (w_full[WIDTH-1] != r_a[DIGIT-1]);
                        r_out_valid <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_cnt       <= '0;
                    r_c         <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign parity    = r_parity;
    assign sign      = r_sign;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_rev_addsub_seq.sv
// Directed self-checking bench for rev_addsub_seq: default DIGIT=2 and a DIGIT=8 instance.
module tb_rev_addsub_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       iv;
    logic       op_sub;
    logic       out_ready;
    logic [7:0] a;
    logic [7:0] b;
    int         sel;

    int n_checks = 0;
    int n_fail   = 0;

    logic       iv0, iv1;
    logic       rdy0, rdy1, vld0, vld1;
    logic [7:0] res0, res1;
    logic       c0, z0, p0, s0, o0;
    logic       c1, z1, p1, s1, o1;

    logic       m_ready, m_valid;
    logic [7:0] m_result;
    logic [4:0] m_flags;

    always #5 clk = ~clk;

    assign iv0 = iv && (sel == 0);
    assign iv1 = iv && (sel == 1);

    rev_addsub_seq #(.WIDTH(8), .DIGIT(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv0),
        .in_ready  (rdy0),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (vld0),
        .out_ready (out_ready),
        .result    (res0),
        .carry     (c0),
        .zero      (z0),
        .parity    (p0),
        .sign      (s0),
        .overflow  (o0)
    );

    rev_addsub_seq #(.WIDTH(8), .DIGIT(8)) u_dut_w (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (iv1),
        .in_ready  (rdy1),
        .op_sub    (op_sub),
        .a         (a),
        .b         (b),
        .out_valid (vld1),
        .out_ready (out_ready),
        .result    (res1),
        .carry     (c1),
        .zero      (z1),
        .parity    (p1),
        .sign      (s1),
        .overflow  (o1)
    );

    // Route the selected instance to a common view; flags packed {carry,zero,parity,sign,overflow}
    always_comb begin
        if (sel == 1) begin
            m_ready  = rdy1;
            m_valid  = vld1;
            m_result = res1;
            m_flags  = {c1, z1, p1, s1, o1};
        end else begin
            m_ready  = rdy0;
            m_valid  = vld0;
            m_result = res0;
            m_flags  = {c0, z0, p0, s0, o0};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_op(input int s, input logic sub, input logic [7:0] ta, input logic [7:0] tb_v,
                          input int exp_lat, input logic [7:0] er, input logic [4:0] ef, input int hold);
        int w;
        int lat;
        sel = s;
        w = 0;
        while (!m_ready && w < 20) begin
            tick();
            w++;
        end
        check_eq("ready_before_op", 32'(m_ready), 32'd1);
        op_sub = sub;
        a      = ta;
        b      = tb_v;
        iv     = 1'b1;
        tick();
        iv     = 1'b0;
        // Scramble inputs after acceptance; they must be ignored
        a      = ~ta;
        b      = ~tb_v;
        op_sub = ~sub;
        check_eq("busy_not_ready", 32'(m_ready), 32'd0);
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
            if (m_valid) break;
        end
        check_eq("latency", 32'(lat), 32'(exp_lat));
        check_eq("result", 32'(m_result), 32'(er));
        check_eq("flags_czpso", 32'(m_flags), 32'(ef));
        for (int i = 0; i < hold; i++) begin
            iv = (i % 2 == 0);
            a  = 8'h11;
            b  = 8'h22;
            tick();
            check_eq("hold_valid", 32'(m_valid), 32'd1);
            check_eq("hold_result", 32'(m_result), 32'(er));
            check_eq("hold_flags", 32'(m_flags), 32'(ef));
            check_eq("hold_not_ready", 32'(m_ready), 32'd0);
        end
        iv        = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("drain_valid_low", 32'(m_valid), 32'd0);
        check_eq("drain_ready_high", 32'(m_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        iv        = 1'b0;
        op_sub    = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sel       = 0;
        repeat (3) tick();
        check_eq("rst_ready", 32'({rdy0, rdy1}), 32'd0);
        check_eq("rst_valid", 32'({vld0, vld1}), 32'd0);
        check_eq("rst_result", 32'({res0, res1}), 32'd0);
        check_eq("rst_flags", 32'({c0, z0, p0, s0, o0, c1, z1, p1, s1, o1}), 32'd0);
        rst = 1'b0;
        tick();
        check_eq("post_rst_ready", 32'({rdy0, rdy1}), 32'b11);

        // {carry, zero, parity, sign, overflow}
        run_op(0, 1'b0, 8'h3C, 8'h45, 4, 8'h81, 5'b00011, 0);
        run_op(0, 1'b1, 8'h10, 8'h10, 4, 8'h00, 5'b11000, 0);
        run_op(0, 1'b0, 8'hFF, 8'h01, 4, 8'h00, 5'b11000, 0);
        run_op(1, 1'b0, 8'hFF, 8'h01, 1, 8'h00, 5'b11000, 0);
        run_op(0, 1'b1, 8'h80, 8'h01, 4, 8'h7F, 5'b10101, 0);
        run_op(1, 1'b1, 8'h80, 8'h01, 1, 8'h7F, 5'b10101, 0);

        // Backpressure with in_valid toggling and new operands presented
        run_op(0, 1'b0, 8'h3C, 8'h45, 4, 8'h81, 5'b00011, 5);

        // Reset during the second RUN cycle aborts the operation
        sel    = 0;
        op_sub = 1'b0;
        a      = 8'h3C;
        b      = 8'h45;
        iv     = 1'b1;
        tick();
        iv     = 1'b0;
        tick();
        rst    = 1'b1;
        tick();
        check_eq("abort_valid", 32'(vld0), 32'd0);
        check_eq("abort_result", 32'(res0), 32'd0);
        check_eq("abort_flags", 32'({c0, z0, p0, s0, o0}), 32'd0);
        check_eq("abort_ready_in_rst", 32'(rdy0), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("abort_stays_idle", 32'({vld0, rdy0}), 32'b01);
        end
        run_op(0, 1'b0, 8'h01, 8'h02, 4, 8'h03, 5'b00000, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
